yarvi_me_arb: RTL and testbench
===============================

Name: yarvi_me_arb

Overview:
- Arbitrates the single-issue memory (load/store) unit between two requesters: the core pipeline (port C) and an auxiliary master (port A, e.g. debug/loader).
- Issues at most one operation per cycle to the memory unit.
- Routes each 1-cycle-later result back to the port that issued it.
- Inserts a bubble where a load would hit the word stored in the previous cycle, so the memory unit never raises load-hit-store.

Parameters:
- STARVE_LIMIT, 8, consecutive cycles port A may wait with c_valid high before it is force-granted (1..2^CNT_W-1).
- CNT_W, 4, width of the starvation counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- c_valid  in  1  core request present
- c_ready  out  1  core request accepted this cycle
- c_write  in  1  store (else load)
- c_funct3  in  3  size/sign: 0 b, 1 h, 2 w, 4 bu, 5 hu
- c_addr  in  32  byte address
- c_wdata  in  32  store data
- c_rd  in  5  destination register tag
- a_valid, a_ready, a_write, a_funct3, a_addr, a_wdata, a_rd  (same widths and meaning as port C, for port A)
- me_valid_o  out  1  issue to memory unit
- me_wb_rd_o  out  5  tag of issued op
- me_addr_o  out  32  address (the memory unit's wb_val input)
- me_we_o  out  1  writeenable
- me_re_o  out  1  readenable
- me_funct3_o  out  3  size
- me_wdata_o  out  32  store data
- me_valid_i  in  1  result valid (1 cycle after issue)
- me_wb_val_i  in  32  result data
- c_resp_valid  out  1  load/bypass result for port C
- a_resp_valid  out  1  load/bypass result for port A
- resp_rd  out  5  result tag (shared)
- resp_data  out  32  result data (shared)

Behaviour:
- Handshake:
  - A request transfers when valid && ready.
  - The requester holds all fields stable while valid && !ready.
  - ready is combinational from state and the valids; it never depends on the memory unit's outputs (no loop).
- Grant policy, FSM states NORMAL, FORCE_A, BUBBLE:
  - NORMAL: C beats A. With both valid, C is granted and starve_cnt increments (saturating). A granted alone when c_valid=0. starve_cnt clears on any A grant or when a_valid=0. Entering the cycle with starve_cnt==STARVE_LIMIT-1 while A still loses, next state is FORCE_A.
  - FORCE_A: A granted if a_valid (c_ready=0), then return to NORMAL with starve_cnt=0. If a_valid has dropped, return to NORMAL with no grant.
  - BUBBLE: no grant (c_ready=a_ready=0, me_valid_o=0) for exactly one cycle, then return to the state saved on entry (NORMAL or FORCE_A).
- Hazard:
  - Registered last_st (1 bit) plus last_addr[31:2] record each issued store.
  - If the winning candidate is a load with last_st && addr[31:2]==last_addr, the FSM enters BUBBLE instead of granting. The same request wins after the bubble.
  - last_st clears on any cycle without an issued store, so a bubble never repeats.
- Issue:
  - me_*_o is a combinational mux of the granted port's fields.
  - me_valid_o = grant; me_we_o = grant & write; me_re_o = grant & !write.
  - Ungranted cycles drive me_valid_o=0, me_we_o=0, me_re_o=0, other fields 0.
- Response:
  - Registered owner bit plus issued_load bit capture the grant each cycle.
  - When me_valid_i=1: exactly one of c_resp_valid/a_resp_valid is high (by owner), resp_rd=registered tag, resp_data=me_wb_val_i.
  - Stores produce a response too (the memory unit bypasses the address); requesters ignore it.
- Reset (async, reset_n=0):
  - FSM=NORMAL, starve_cnt=0, last_st=0, owner=0.
  - c_resp_valid=a_resp_valid=0, resp_rd=0, resp_data=0.
  - me_valid_o and the ready outputs are 0 while reset_n=0.
  - An operation issued in the cycle reset asserts has its response dropped.
- Simultaneous: hazard check applies to whichever port would be granted, including in FORCE_A.

Decomposition:
- Shared package yarvi_me_pkg:
  - funct3 encodings (LB/LH/LW/LBU/LHU).
  - FSM state enum.
  - Port-id constants PORT_C=0, PORT_A=1.
- One sub-module: yarvi_me_arb_hazard, holding the last-store register and word compare and emitting need_bubble.

Test Plan:
- C only: load addr 0x80000010, rd=5, me_wb_val_i=0x12345678 -> me_valid_o same cycle; next cycle c_resp_valid=1, resp_rd=5, resp_data=0x12345678; a_resp_valid=0.
- Both valid continuously, STARVE_LIMIT=8 -> C granted 8 cycles, A granted in cycle 9 (c_ready=0), C granted cycle 10; starve_cnt back to 0.
- C store to 0x80000020, then C load 0x80000022 -> one bubble cycle (me_valid_o=0, c_ready=0), load issues the following cycle.
- Store 0x80000020 then load 0x80000024 -> no bubble, back-to-back issue.
- A alone, store then load same word in FORCE_A -> bubble, then A load granted, FSM returns to NORMAL.
- Assert reset_n=0 mid-traffic (issue cycle) -> all outputs 0 immediately, next response suppressed, after release first grant goes to C if valid.

Source files
------------

// File: rtl/yarvi_me_pkg.sv
// Shared types and constants for the memory-unit arbiter: funct3 codes,
// FSM state encodings, port ids and the request payload struct.
package yarvi_me_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned WORD_W = ADDR_W - 2;

  localparam logic [F3_W-1:0] F3_LB  = 3'd0;
  localparam logic [F3_W-1:0] F3_LH  = 3'd1;
  localparam logic [F3_W-1:0] F3_LW  = 3'd2;
  localparam logic [F3_W-1:0] F3_LBU = 3'd4;
  localparam logic [F3_W-1:0] F3_LHU = 3'd5;

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_FORCE_A = 2'd1;
  localparam logic [1:0] ST_BUBBLE  = 2'd2;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_A = 1'b1;

  typedef struct packed {
    logic              write;
    logic [F3_W-1:0]   funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  rd;
  } me_req_t;

endpackage

// File: rtl/yarvi_me_arb_if.sv
// Requester-side bundle of the arbiter: core (c_*) and auxiliary (a_*)
// request handshakes plus the shared result return path.
interface yarvi_me_arb_if;
  import yarvi_me_pkg::*;

  logic              c_valid;
  logic              c_ready;
  logic              c_write;
  logic [F3_W-1:0]   c_funct3;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [TAG_W-1:0]  c_rd;

  logic              a_valid;
  logic              a_ready;
  logic              a_write;
  logic [F3_W-1:0]   a_funct3;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [TAG_W-1:0]  a_rd;

  logic              c_resp_valid;
  logic              a_resp_valid;
  logic [TAG_W-1:0]  resp_rd;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output c_valid, c_write, c_funct3, c_addr, c_wdata, c_rd,
    output a_valid, a_write, a_funct3, a_addr, a_wdata, a_rd,
    input  c_ready, a_ready, c_resp_valid, a_resp_valid, resp_rd, resp_data
  );

  modport slave (
    input  c_valid, c_write, c_funct3, c_addr, c_wdata, c_rd,
    input  a_valid, a_write, a_funct3, a_addr, a_wdata, a_rd,
    output c_ready, a_ready, c_resp_valid, a_resp_valid, resp_rd, resp_data
  );

endinterface

// File: rtl/yarvi_me_arb_hazard.sv
// Remembers the word written by the store issued last cycle and flags a
// candidate load to that same word so the arbiter can insert a bubble.
module yarvi_me_arb_hazard
  import yarvi_me_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              st_issue_i,
  input  logic [WORD_W-1:0] st_word_i,
  input  logic              cand_load_i,
  input  logic [WORD_W-1:0] cand_word_i,
  output logic              need_bubble_o
);

  logic              last_st_q;
  logic [WORD_W-1:0] last_addr_q;

  // last_st only survives one cycle, so a bubble can never repeat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_st_q   <= 1'b0;
      last_addr_q <= '0;
    end else begin
      last_st_q <= st_issue_i;
      if (st_issue_i) last_addr_q <= st_word_i;
    end
  end

  assign need_bubble_o = cand_load_i & last_st_q & (cand_word_i == last_addr_q);

endmodule

// File: rtl/yarvi_me_arb.sv
// Single-issue memory-unit arbiter between the core pipeline (C) and an
// auxiliary master (A), with starvation relief and load-hit-store bubbles.
module yarvi_me_arb
  import yarvi_me_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  yarvi_me_arb_if.slave     req,
  output logic              me_valid_o,
  output logic [TAG_W-1:0]  me_wb_rd_o,
  output logic [ADDR_W-1:0] me_addr_o,
  output logic              me_we_o,
  output logic              me_re_o,
  output logic [F3_W-1:0]   me_funct3_o,
  output logic [DATA_W-1:0] me_wdata_o,
  input  logic              me_valid_i,
  input  logic [DATA_W-1:0] me_wb_val_i
);

  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_q, saved_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic    cand_c, cand_a, cand_any;
  logic    need_bubble;
  logic    grant_c, grant_a, grant;
  me_req_t c_req, a_req, cand_req, issue_req;

  logic             issued_q, owner_q;
  logic [TAG_W-1:0] rd_q;
  logic             resp_fire;

  assign c_req = {req.c_write, req.c_funct3, req.c_addr, req.c_wdata, req.c_rd};
  assign a_req = {req.a_write, req.a_funct3, req.a_addr, req.a_wdata, req.a_rd};

  // Port that would win this cycle, before the hazard check
  always_comb begin
    cand_c = 1'b0;
    cand_a = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        cand_c = req.c_valid;
        cand_a = req.a_valid & ~req.c_valid;
      end
      ST_FORCE_A: cand_a = req.a_valid;
      default: ;
    endcase
  end

  assign cand_any = cand_c | cand_a;
  assign cand_req = cand_a ? a_req : c_req;

  yarvi_me_arb_hazard u_hazard (
    .clock         (clock),
    .reset_n       (reset_n),
    .st_issue_i    (issue_req.write),
    .st_word_i     (issue_req.addr[ADDR_W-1:2]),
    .cand_load_i   (cand_any & ~cand_req.write),
    .cand_word_i   (cand_req.addr[ADDR_W-1:2]),
    .need_bubble_o (need_bubble)
  );

  assign grant_c = reset_n & cand_c & ~need_bubble;
  assign grant_a = reset_n & cand_a & ~need_bubble;
  assign grant   = grant_c | grant_a;

  assign req.c_ready = grant_c;
  assign req.a_ready = grant_a;

  assign issue_req   = grant ? cand_req : '0;
  assign me_valid_o  = grant;
  assign me_we_o     = issue_req.write;
  assign me_re_o     = grant & ~issue_req.write;
  assign me_funct3_o = issue_req.funct3;
  assign me_addr_o   = issue_req.addr;
  assign me_wdata_o  = issue_req.wdata;
  assign me_wb_rd_o  = issue_req.rd;

  // Grant state machine; starve_q counts consecutive C wins over a waiting A
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    starve_d = starve_q;
    case (state_q)
      ST_NORMAL: begin
        if (need_bubble) begin
          state_d = ST_BUBBLE;
          saved_d = ST_NORMAL;
          if (!req.a_valid) starve_d = '0;
        end else if (!req.a_valid || grant_a) begin
          starve_d = '0;
        end else if (grant_c) begin
          if (starve_q == CNT_TRIP) state_d = ST_FORCE_A;
          if (starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
        end
      end
      ST_FORCE_A: begin
        if (need_bubble) begin
          state_d = ST_BUBBLE;
          saved_d = ST_FORCE_A;
        end else begin
          state_d  = ST_NORMAL;
          starve_d = '0;
        end
      end
      default: begin
        state_d = saved_q;
        if (!req.a_valid) starve_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_NORMAL;
      saved_q  <= ST_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      starve_q <= starve_d;
    end
  end

  // Issue bookkeeping so the next-cycle result can be routed to its owner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_q <= 1'b0;
      owner_q  <= PORT_C;
      rd_q     <= '0;
    end else begin
      issued_q <= grant;
      owner_q  <= grant_a ? PORT_A : PORT_C;
      rd_q     <= issue_req.rd;
    end
  end

  assign resp_fire        = reset_n & issued_q & me_valid_i;
  assign req.c_resp_valid = resp_fire & (owner_q == PORT_C);
  assign req.a_resp_valid = resp_fire & (owner_q == PORT_A);
  assign req.resp_rd      = rd_q;
  assign req.resp_data    = resp_fire ? me_wb_val_i : '0;

endmodule

// File: tb/tb_yarvi_me_arb.sv
// Random-traffic bench for yarvi_me_arb: a behavioural grant model predicts
// every issue, and a scoreboard checks results routed back to each port.
module tb_yarvi_me_arb;
  import yarvi_me_pkg::*;

  localparam int unsigned LIMIT = 8;
  localparam logic [31:0] KEY   = 32'h5A5A_0F0F;

  typedef struct {
    bit        write;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [4:0]  rd;
  } rq_t;

  typedef struct {
    bit        port;
    bit [4:0]  rd;
    bit [31:0] data;
    int        due;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  yarvi_me_arb_if bus ();

  logic        me_valid_o, me_we_o, me_re_o;
  logic [4:0]  me_wb_rd_o;
  logic [31:0] me_addr_o, me_wdata_o;
  logic [2:0]  me_funct3_o;
  logic        me_valid_i = 1'b0;
  logic [31:0] me_wb_val_i = 32'h0;

  yarvi_me_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (bus),
    .me_valid_o  (me_valid_o),
    .me_wb_rd_o  (me_wb_rd_o),
    .me_addr_o   (me_addr_o),
    .me_we_o     (me_we_o),
    .me_re_o     (me_re_o),
    .me_funct3_o (me_funct3_o),
    .me_wdata_o  (me_wdata_o),
    .me_valid_i  (me_valid_i),
    .me_wb_val_i (me_wb_val_i)
  );

  // Stand-in memory unit: loads return addr^KEY, stores bypass the address
  always @(posedge clock) begin
    me_valid_i  <= me_valid_o;
    me_wb_val_i <= me_we_o ? me_addr_o : (me_addr_o ^ KEY);
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  exp_t sb[$];
  logic [2:0] f3_tab [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

  bit  c_pend, a_pend;
  rq_t c_r, a_r;

  // Reference model state: A's losing streak, owed turn, bubble, last store word
  int        m_wait;
  bit        m_force, m_bubble, m_last_st;
  bit [29:0] m_last_word;
  bit        p_c, p_a, haz, g_c, g_a;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rq_t rand_req();
    rq_t r;
    r.write = ($urandom_range(0, 9) < 4);
    r.f3    = f3_tab[$urandom_range(0, 4)];
    r.addr  = 32'h8000_0000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
    r.wdata = $urandom;
    r.rd    = 5'($urandom);
    return r;
  endfunction

  function automatic logic [79:0] issue_vec(input bit g, input rq_t r);
    if (!g) return '0;
    return 80'({1'b1, r.write, !r.write, r.f3, r.addr, r.wdata, r.rd});
  endfunction

  task automatic drive();
    bus.c_valid  = c_pend;
    bus.c_write  = c_r.write;
    bus.c_funct3 = c_r.f3;
    bus.c_addr   = c_r.addr;
    bus.c_wdata  = c_r.wdata;
    bus.c_rd     = c_r.rd;
    bus.a_valid  = a_pend;
    bus.a_write  = a_r.write;
    bus.a_funct3 = a_r.f3;
    bus.a_addr   = a_r.addr;
    bus.a_wdata  = a_r.wdata;
    bus.a_rd     = a_r.rd;
  endtask

  task automatic model_reset();
    m_wait = 0; m_force = 0; m_bubble = 0; m_last_st = 0; m_last_word = '0;
    g_c = 0; g_a = 0;
  endtask

  task automatic predict_and_check();
    rq_t  pr;
    exp_t e;
    p_c = 0; p_a = 0;
    if (!m_bubble) begin
      if (m_force) p_a = a_pend;
      else if (c_pend) p_c = 1;
      else p_a = a_pend;
    end
    pr  = p_a ? a_r : c_r;
    haz = (p_c || p_a) && !pr.write && m_last_st && (pr.addr[31:2] == m_last_word);
    g_c = p_c && !haz;
    g_a = p_a && !haz;
    check("c_ready", 80'(bus.c_ready), 80'(g_c));
    check("a_ready", 80'(bus.a_ready), 80'(g_a));
    check("issue", 80'({me_valid_o, me_we_o, me_re_o, me_funct3_o, me_addr_o, me_wdata_o, me_wb_rd_o}),
          issue_vec(g_c || g_a, pr));
    if (g_c || g_a) begin
      e.port = g_a;
      e.rd   = pr.rd;
      e.data = pr.write ? pr.addr : (pr.addr ^ KEY);
      e.due  = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic model_update();
    rq_t gr;
    gr = g_a ? a_r : c_r;
    m_last_st = (g_c || g_a) && gr.write;
    if (m_last_st) m_last_word = gr.addr[31:2];
    if (m_bubble) begin
      m_bubble = 0;
      if (!a_pend) m_wait = 0;
    end else if (haz) begin
      m_bubble = 1;
      if (!a_pend) m_wait = 0;
    end else if (m_force) begin
      m_force = 0;
      m_wait  = 0;
    end else if (!a_pend || g_a) begin
      m_wait = 0;
    end else if (g_c) begin
      m_wait++;
      if (m_wait == LIMIT) m_force = 1;
    end
  endtask

  task automatic step(input int pc, input int pa);
    @(negedge clock);
    predict_and_check();
    @(posedge clock);
    model_update();
    #1;
    if (g_c) c_pend = 0;
    if (g_a) a_pend = 0;
    if (!c_pend && int'($urandom_range(0, 99)) < pc) begin c_r = rand_req(); c_pend = 1; end
    if (!a_pend && int'($urandom_range(0, 99)) < pa) begin a_r = rand_req(); a_pend = 1; end
    drive();
  endtask

  // Result monitor: every routed result must match the oldest issued op
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (bus.c_resp_valid || bus.a_resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 80'({bus.c_resp_valid, bus.a_resp_valid}), 80'(0));
        end else begin
          e = sb.pop_front();
          check("resp_port", 80'({bus.c_resp_valid, bus.a_resp_valid}), 80'(e.port ? 2'b01 : 2'b10));
          check("resp_rd", 80'(bus.resp_rd), 80'(e.rd));
          check("resp_data", 80'(bus.resp_data), 80'(e.data));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("resp_missing", 80'(0), 80'(1));
      end
    end
  end

  initial begin
    model_reset();
    c_r = rand_req(); a_r = rand_req();
    c_pend = 1; a_pend = 1;
    drive();
    @(negedge clock);
    check("reset_outputs",
          80'({me_valid_o, me_we_o, me_re_o, bus.c_ready, bus.a_ready,
               bus.c_resp_valid, bus.a_resp_valid, bus.resp_rd, bus.resp_data}), 80'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 60;  i++) step(100, 100);
    for (int i = 0; i < 200; i++) step(70, 50);

    // Reset right after an issue: outputs clear at once and the result is dropped
    for (int k = 0; k < 50 && !(g_c || g_a); k++) step(70, 50);
    reset_n = 1'b0;
    @(negedge clock);
    check("midreset_outputs",
          80'({me_valid_o, me_we_o, me_re_o, bus.c_ready, bus.a_ready,
               bus.c_resp_valid, bus.a_resp_valid, bus.resp_rd, bus.resp_data}), 80'(0));
    sb.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();

    for (int i = 0; i < 80;  i++) step(0, 90);
    for (int i = 0; i < 150; i++) step(40, 40);
    for (int i = 0; i < 150; i++) step(100, 100);
    for (int i = 0; i < 20;  i++) step(0, 0);
    @(negedge clock);
    check("sb_drained", 80'(sb.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
